// File: rtl/ram_port_arb.sv
// Arbiter sharing one pipelined data-RAM port between the CPU and a debug/loader master.
// Every issued slot carries an owner tag so read return (t+1) and write-back (t+2) reach the right master.
module ram_port_arb #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CPU_VALID,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic              CPU_LOCK,
    input  logic              CPU_WEN,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              CPU_STALL,
    input  logic              LD_REQ,
    input  logic              LD_WE,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [DATA_W-1:0] LD_WDATA,
    output logic              LD_GNT,
    output logic [DATA_W-1:0] LD_RDATA,
    output logic              LD_RVALID,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_IN,
    output logic              RAM_WEN,
    input  logic [DATA_W-1:0] RAM_OUT
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {S_CPU, S_LD, S_YIELD} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_LD} tag_t;

    state_t            state;
    logic [CNT_W-1:0]  burst_cnt;
    logic              ld_accept;
    tag_t              tag_p0, tag_p1, tag_p2;
    logic              ld_we_p1, ld_we_p2;
    logic [DATA_W-1:0] ld_wdata_p1, ld_wdata_p2;

    assign ld_accept = (state == S_LD) && LD_REQ;

    // Grant and stall are pure decodes of the state register, never of LD_REQ.
    assign LD_GNT    = (state == S_LD);
    assign CPU_STALL = (state == S_LD);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_CPU;
            burst_cnt <= '0;
        end else begin
            case (state)
                S_CPU: begin
                    if (LD_REQ && !CPU_LOCK) begin
                        state     <= S_LD;
                        burst_cnt <= '0;
                    end
                end
                S_LD: begin
                    if (!LD_REQ) begin
                        state <= S_CPU;
                    end else if (burst_cnt == CNT_LAST) begin
                        state     <= S_YIELD;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                S_YIELD: begin
                    state     <= LD_REQ ? S_LD : S_CPU;
                    burst_cnt <= '0;
                end
                default: begin
                    state     <= S_CPU;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    // Stage p0: address issue and owner tag for this slot
    assign RAM_ADDR = ld_accept ? LD_ADDR : CPU_ADDR;

    always_comb begin
        tag_p0 = TAG_NONE;
        if (ld_accept)
            tag_p0 = TAG_LD;
        else if ((state != S_LD) && CPU_VALID)
            tag_p0 = TAG_CPU;
    end

    // Stage p1/p2: tag and loader write payload travel with the slot
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tag_p1      <= TAG_NONE;
            tag_p2      <= TAG_NONE;
            ld_we_p1    <= 1'b0;
            ld_we_p2    <= 1'b0;
            ld_wdata_p1 <= '0;
            ld_wdata_p2 <= '0;
        end else begin
            tag_p1      <= tag_p0;
            tag_p2      <= tag_p1;
            ld_we_p1    <= LD_WE;
            ld_we_p2    <= ld_we_p1;
            ld_wdata_p1 <= LD_WDATA;
            ld_wdata_p2 <= ld_wdata_p1;
        end
    end

    // Read return at p1; a stalled CPU cannot write because CPU_WEN only counts on CPU slots
    assign LD_RVALID = (tag_p1 == TAG_LD) && !ld_we_p1;
    assign LD_RDATA  = RAM_OUT;

    always_comb begin
        RAM_WEN = 1'b0;
        RAM_IN  = CPU_WDATA;
        case (tag_p2)
            TAG_CPU: RAM_WEN = CPU_WEN;
            TAG_LD: begin
                RAM_WEN = ld_we_p2;
                RAM_IN  = ld_wdata_p2;
            end
            default: RAM_WEN = 1'b0;
        endcase
    end

endmodule
